// File: rtl/rx_ctrl_pkg.sv
// Shared types for the UART receive-side controller: FSM states and the
// 9-bit buffered entry layout {perr, data}.
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        ACK
    } rx_ctrl_state_t;

    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_ctrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is read
// combinationally from storage. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is still accepted when it coincides with a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage write port; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update; both pointers wrap naturally through the extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_ctrl.sv
// Receive-side controller: runs the Receive/ReceiveAck four-phase handshake
// with the UART rx block, captures each byte exactly once, tags it with its
// parity status, buffers it, and keeps wrap-around character/error counts.
module rx_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_ON_PARITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_receive,
    input  logic [7:0] rx_dout,
    input  logic       rx_parity_err,
    output logic       rx_ack,
    output logic [7:0] data_out,
    output logic       data_perr,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [7:0] char_count,
    output logic [7:0] err_count,
    output logic       overflow
);

    rx_ctrl_state_t state_reg;
    rx_ctrl_state_t state_next;

    logic       capture;
    logic       want_push;
    logic       push_fire;
    logic       pop_fire;
    logic       byte_lost;
    logic       fifo_full;
    logic       fifo_empty;
    rx_entry_t  entry_in;
    rx_entry_t  entry_out;

    logic       rx_ack_reg;
    logic [7:0] char_count_reg;
    logic [7:0] err_count_reg;
    logic       overflow_reg;

    // Next-state logic; a capture happens only on the IDLE->ACK transition.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            FLUSH: begin
                // Wait out any byte still held across reset.
                if (!rx_receive) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (rx_receive) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!rx_receive) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = FLUSH;
            end
        endcase
    end

    assign pop_fire  = !fifo_empty && data_ready;
    assign want_push = capture && !((DROP_ON_PARITY != 0) && rx_parity_err);
    assign push_fire = want_push && (!fifo_full || pop_fire);
    assign byte_lost = want_push && fifo_full && !pop_fire;

    assign entry_in.perr = rx_parity_err;
    assign entry_in.data = rx_dout;

    // State register and the registered acknowledge, which mirrors ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FLUSH;
            rx_ack_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rx_ack_reg <= (state_next == ACK);
        end
    end

    // Character/error counters (free-wrapping) and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_count_reg <= 8'd0;
            err_count_reg  <= 8'd0;
            overflow_reg   <= 1'b0;
        end else begin
            if (capture) begin
                char_count_reg <= char_count_reg + 8'd1;
                if (rx_parity_err) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
            end
            if (byte_lost) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_fire),
        .pop   (pop_fire),
        .din   (entry_in),
        .dout  (entry_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_ack     = rx_ack_reg;
    assign data_out   = entry_out.data;
    assign data_perr  = entry_out.perr;
    assign data_valid = !fifo_empty;
    assign char_count = char_count_reg;
    assign err_count  = err_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-side controller between the UART `rx` module and the byte consumer.
- Drives the four-phase `Receive`/`ReceiveAck` handshake itself, capturing each byte exactly once.
- Tags each byte with its parity status and buffers it in a small first-word-fall-through FIFO.
- Maintains wrap-around character and parity-error counts for the seven-segment display path.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: buffer entries; must be a power of two and at least 2.
- `DROP_ON_PARITY`, default 0: when 1, bytes with a parity error are counted but not buffered.

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `rx_receive`  in  1  `Receive` from `rx`; high while a byte is held.
- `rx_dout`  in  8  `Dout` from `rx`; valid while `rx_receive` is high.
- `rx_parity_err`  in  1  `parityErr` from `rx`; valid while `rx_receive` is high.
- `rx_ack`  out  1  to `rx` `ReceiveAck`; registered.
- `data_out`  out  8  FIFO head byte.
- `data_perr`  out  1  parity flag of the FIFO head.
- `data_valid`  out  1  FIFO is non-empty.
- `data_ready`  in  1  consumer pop request.
- `char_count`  out  8  bytes received from `rx`, including dropped bytes.
- `err_count`  out  8  bytes received with a parity error.
- `overflow`  out  1  sticky: a byte was lost because the FIFO was full.

## Operation
FSM states: FLUSH, IDLE, ACK.
- **FLUSH** (reset state): `rx_ack=0`. Go to IDLE when `rx_receive=0`. This prevents re-capturing a byte that was held across reset.
- **IDLE**: `rx_ack=0`. When `rx_receive=1`, on that edge:
  - capture `{rx_parity_err, rx_dout}`;
  - `char_count += 1`;
  - `err_count += 1` if `rx_parity_err`;
  - push to the FIFO, unless the FIFO is full (then set `overflow`) or `DROP_ON_PARITY && rx_parity_err`;
  - go to ACK.
- **ACK**: `rx_ack=1`. Stay while `rx_receive=1`. Go to IDLE when `rx_receive=0`. No capture happens in ACK.

FIFO:
- Entry width is 9 bits: `{perr, data}`.
- `data_out`/`data_perr` show the head combinationally from storage while `data_valid=1`. They are don't-care when the FIFO is empty.
- Pop happens when `data_valid && data_ready`. A pop while empty is ignored.

Counters:
- 8-bit, wrap from 255 to 0; no saturation.
- Overflow and parity drops still increment `char_count`.

## Timing
- Reset values: `rx_ack=0`, `data_valid=0`, `char_count=0`, `err_count=0`, `overflow=0`, FIFO empty, state FLUSH.
- Reset takes priority over every other event, including mid-handshake and a pending pop.
- Capture latency: `rx_receive` is sampled high in IDLE at edge k. After edge k:
  - `rx_ack=1`;
  - counts are updated;
  - `data_valid=1` (if the push occurred).
- Release: `rx_receive` is sampled low in ACK at edge m; `rx_ack=0` after edge m. The earliest next capture is at edge m+1.
- Push and pop in the same cycle:
  - FIFO non-empty and not full: both occur; occupancy is unchanged.
  - FIFO full: the pop frees a slot and the push is accepted; `overflow` is not set.
  - FIFO empty: the pop is ignored and the push is accepted; `data_valid=1` next cycle.
- `overflow` clears only on `rst`.
- Occupancy is tracked with pointers one bit wider than `log2(FIFO_DEPTH)`.
  - full: MSBs differ and the rest are equal.
  - empty: pointers are equal.
  - Pointers wrap naturally.

## Structure
- Package `rx_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {FLUSH, IDLE, ACK} rx_ctrl_state_t`;
  - `localparam ENTRY_W = 9`;
  - `typedef struct packed {logic perr; logic [7:0] data;} rx_entry_t`.
- One sub-module, `sync_fifo`, parameterised by width and depth, with `clk`, `rst`, `push`, `pop`, `din`, `dout`, `full`, `empty`.
- `rx_ctrl` contains the FSM, counters, overflow flag and push/drop decision.

## Test plan
- **Single byte:** hold `rx_receive=1` with `rx_dout=8'h41` and `rx_parity_err=0` for 5 cycles, then drop it.
  - `rx_ack` rises one cycle after `rx_receive` and falls one cycle after it drops.
  - `data_out=8'h41`, `data_valid=1`, `char_count=1`, `err_count=0`.
- **Parity error, `DROP_ON_PARITY=0` then 1:** send `8'h55` with `rx_parity_err=1`.
  - Both settings: `err_count=1`, `char_count=1`.
  - Setting 0: entry buffered with `data_perr=1`.
  - Setting 1: `data_valid` stays 0.
- **Overflow:** with `data_ready=0`, send 5 bytes `8'h01` to `8'h05` (depth 4).
  - `overflow=1`, `char_count=5`.
  - Popping yields `01, 02, 03, 04`, then `data_valid=0`.
- **Full with push and pop:** with the FIFO full, pop in the same cycle as a new capture of `8'hAA`.
  - `overflow` stays 0; `8'hAA` is the last entry popped.
- **Reset mid-handshake:** assert `rst` while in ACK with `rx_receive` held high.
  - All outputs return to reset values.
  - No capture occurs until `rx_receive` goes low and then high again; the next byte gives `char_count=1`.
- **Wrap:** send 256 bytes, all with parity error, popping continuously.
  - `char_count=0` and `err_count=0` after the 256th byte; `overflow=0`.
